// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI burst slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  // Command word is the R/W flag followed by the register address.
  function automatic int cmd_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronises the SPI pins into clk_i and derives SCLK rise/fall strobes.
// CS and MOSI share the SCLK depth so data stays aligned with the detected edge.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_active_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_q_r;
  logic [SYNC_STAGES-1:0] cs_q_r;
  logic [SYNC_STAGES-1:0] mosi_q_r;
  logic                   sclk_prev_r;

  // Synchroniser chains plus one extra SCLK sample for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q_r    <= {SYNC_STAGES{1'b0}};
      cs_q_r      <= {SYNC_STAGES{1'b1}};
      mosi_q_r    <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_q_r    <= {sclk_q_r[SYNC_STAGES-2:0], sclk_i};
      cs_q_r      <= {cs_q_r[SYNC_STAGES-2:0], cs_i};
      mosi_q_r    <= {mosi_q_r[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_r <= sclk_q_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_q_r[SYNC_STAGES-1] & ~sclk_prev_r;
  assign sclk_fall_o = ~sclk_q_r[SYNC_STAGES-1] & sclk_prev_r;
  assign cs_active_o = ~cs_q_r[SYNC_STAGES-1];
  assign mosi_o      = mosi_q_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_burst_slave.sv
// SPI mode-0 burst slave bridging a host to the register bank.
// Build option SPI_ADDR_INC_EN: auto-increment the address after each data word.
module spi_burst_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  output logic              xfer_active_o
);

  import spi_pkg::*;

  localparam int CMD_W = cmd_width(ADDR_W);
  localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_ADDR_INC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1'b1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = {ADDR_W{1'b0}};
`endif

  logic sclk_rise_s, sclk_fall_s, cs_active_s, mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_i      (sclk_i),
    .cs_i        (cs_i),
    .mosi_i      (mosi_i),
    .sclk_rise_o (sclk_rise_s),
    .sclk_fall_o (sclk_fall_s),
    .cs_active_o (cs_active_s),
    .mosi_o      (mosi_s)
  );

  spi_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [ADDR_W-1:0] cmd_sh_r;
  logic [DATA_W-2:0] data_sh_r;
  logic [DATA_W-1:0] out_sh_r, hold_r, wdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r, re_r, re_d_r, load_pend_r, is_write_r;
  logic              cmd_done_s, word_done_s;
  logic [CMD_W-1:0]  cmd_word_s;
  logic [DATA_W-1:0] data_word_s;

  assign cmd_word_s  = {cmd_sh_r, mosi_s};
  assign data_word_s = {data_sh_r, mosi_s};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; a CS release always wins, so a word ending on that edge is dropped
  always_comb begin
    state_nxt_s = state_r;
    cmd_done_s  = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_active_s) state_nxt_s = CMD;
        else             state_nxt_s = IDLE;
      end
      CMD: begin
        if (!cs_active_s) begin
          state_nxt_s = IDLE;
        end else if (sclk_rise_s && (bit_cnt_r == CMD_LAST)) begin
          state_nxt_s = DATA;
          cmd_done_s  = 1'b1;
        end else begin
          state_nxt_s = CMD;
        end
      end
      DATA: begin
        if (!cs_active_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
          if (sclk_rise_s && (bit_cnt_r == DATA_LAST)) word_done_s = 1'b1;
          else                                          word_done_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Shifters, bit counter, address counter and register strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_r   <= CNT_ZERO;
      cmd_sh_r    <= {ADDR_W{1'b0}};
      data_sh_r   <= {(DATA_W-1){1'b0}};
      out_sh_r    <= {DATA_W{1'b0}};
      hold_r      <= {DATA_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      re_d_r      <= 1'b0;
      load_pend_r <= 1'b0;
      is_write_r  <= 1'b0;
    end else begin
      we_r   <= 1'b0;
      re_r   <= 1'b0;
      re_d_r <= re_r;
      if (re_d_r) hold_r <= reg_rdata_i;
      // Address moves only after the write pulse so it is stable under reg_we_o
      if (we_r) addr_r <= addr_r + ADDR_STEP;
      case (state_r)
        CMD: begin
          if (cs_active_s && sclk_rise_s) begin
            cmd_sh_r <= cmd_word_s[ADDR_W-1:0];
            if (cmd_done_s) begin
              bit_cnt_r  <= CNT_ZERO;
              is_write_r <= cmd_word_s[ADDR_W];
              addr_r     <= cmd_word_s[ADDR_W-1:0];
              if (!cmd_word_s[ADDR_W]) begin
                re_r        <= 1'b1;
                load_pend_r <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
          end
        end
        DATA: begin
          if (!cs_active_s) begin
            out_sh_r <= {DATA_W{1'b0}};
          end else begin
            if (sclk_rise_s) begin
              data_sh_r <= data_word_s[DATA_W-2:0];
              if (word_done_s) begin
                bit_cnt_r <= CNT_ZERO;
                if (is_write_r) begin
                  wdata_r <= data_word_s;
                  we_r    <= 1'b1;
                end else begin
                  addr_r      <= addr_r + ADDR_STEP;
                  re_r        <= 1'b1;
                  load_pend_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end
            if (sclk_fall_s) begin
              if (load_pend_r) begin
                out_sh_r    <= hold_r;
                load_pend_r <= 1'b0;
              end else begin
                out_sh_r <= {out_sh_r[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        default: begin
          bit_cnt_r   <= CNT_ZERO;
          cmd_sh_r    <= {ADDR_W{1'b0}};
          data_sh_r   <= {(DATA_W-1){1'b0}};
          out_sh_r    <= {DATA_W{1'b0}};
          load_pend_r <= 1'b0;
          is_write_r  <= 1'b0;
        end
      endcase
    end
  end

  assign miso_o        = out_sh_r[DATA_W-1];
  assign reg_wdata_o   = wdata_r;
  assign reg_addr_o    = addr_r;
  assign reg_we_o      = we_r;
  assign reg_re_o      = re_r;
  assign xfer_active_o = (state_r != IDLE);

endmodule

// File: tb/tb_spi_burst_slave.sv
// Directed self-checking bench for spi_burst_slave (either SPI_ADDR_INC_EN build).
module tb_spi_burst_slave;

  localparam int HALF = 8;
`ifdef SPI_ADDR_INC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       sclk_i = 1'b0;
  logic       cs_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       miso_o;
  logic [7:0] reg_rdata_i = 8'h00;
  logic [7:0] reg_wdata_o;
  logic [6:0] reg_addr_o;
  logic       reg_we_o, reg_re_o, xfer_active_o;

  spi_burst_slave dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sclk_i        (sclk_i),
    .cs_i          (cs_i),
    .mosi_i        (mosi_i),
    .miso_o        (miso_o),
    .reg_rdata_i   (reg_rdata_i),
    .reg_wdata_o   (reg_wdata_o),
    .reg_addr_o    (reg_addr_o),
    .reg_we_o      (reg_we_o),
    .reg_re_o      (reg_re_o),
    .xfer_active_o (xfer_active_o)
  );

  always #5 clk_i = ~clk_i;

  int         tests = 0;
  int         failed = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         both_cnt = 0;
  int         re_at_data = 0;
  int         rd_mode = 0;
  logic [6:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [6:0] re_addr_q[$];
  logic [7:0] tx[4];
  logic [7:0] rx[4];

  // Register-bank model and strobe monitor; read data appears the cycle after reg_re_o
  always @(negedge clk_i) begin
    if (reg_we_o) begin
      we_cnt++;
      we_addr_q.push_back(reg_addr_o);
      we_data_q.push_back(reg_wdata_o);
    end
    if (reg_re_o) begin
      re_cnt++;
      re_addr_q.push_back(reg_addr_o);
      reg_rdata_i = (rd_mode == 0) ? 8'hA5 : ({1'b0, reg_addr_o} ^ 8'hFF);
    end
    if (reg_we_o && reg_re_o) both_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // end_mode: 0 = normal CS release, 1 = CS released with the last rise, 2 = leave CS low
  task automatic spi_frame(input logic [7:0] cmd, input int ndata, input int end_mode);
    int   total;
    logic b;
    total = 8 + ndata;
    for (int w = 0; w < 4; w++) rx[w] = 8'h00;
    cs_i = 1'b0;
    wait_clks(HALF);
    for (int k = 0; k < total; k++) begin
      if (k < 8) b = cmd[7-k];
      else       b = tx[(k-8)/8][7-((k-8)%8)];
      mosi_i = b;
      wait_clks(HALF);
      if (k == 8) re_at_data = re_cnt;
      sclk_i = 1'b1;
      if (k >= 8) rx[(k-8)/8][7-((k-8)%8)] = miso_o;
      if ((k == total - 1) && (end_mode == 1)) cs_i = 1'b1;
      wait_clks(HALF);
      sclk_i = 1'b0;
    end
    mosi_i = 1'b0;
    if (end_mode == 0) begin
      wait_clks(HALF);
      cs_i = 1'b1;
    end
    if (end_mode != 2) wait_clks(4 * HALF);
  endtask

  initial begin
    int         wb, rb;
    logic [6:0] ea;

    // Reset state
    wait_clks(3);
    chk("reset_outputs", {reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, miso_o, xfer_active_o}, 32'h0);
    rst_ni = 1'b1;
    wait_clks(4);
    chk("idle_after_reset", {31'h0, xfer_active_o}, 32'h0);

    // 1: single write 0x05 -> 0x12
    wb = we_cnt; rb = re_cnt;
    tx[0] = 8'h05;
    spi_frame(8'h92, 8, 0);
    chk("t1_we_count", we_cnt - wb, 1);
    chk("t1_we_addr", we_addr_q[wb], 7'h12);
    chk("t1_we_data", we_data_q[wb], 8'h05);
    chk("t1_no_re", re_cnt - rb, 0);
    chk("t1_addr_after", reg_addr_o, 7'(8'h12 + STEP));
    chk("t1_idle", xfer_active_o, 1'b0);

    // 2: single read of 0x12, model returns 0xA5
    rd_mode = 0;
    wb = we_cnt; rb = re_cnt;
    spi_frame(8'h12, 8, 0);
    chk("t2_re_before_data", re_at_data - rb, 1);
    chk("t2_re_addr", re_addr_q[rb], 7'h12);
    chk("t2_miso_word", rx[0], 8'hA5);
    chk("t2_re_total", re_cnt - rb, 2);
    chk("t2_no_we", we_cnt - wb, 0);

    // 3: burst write from 0x7E
    wb = we_cnt;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    spi_frame(8'hFE, 24, 0);
    chk("t3_we_count", we_cnt - wb, 3);
    for (int i = 0; i < 3; i++) begin
      ea = 7'(8'h7E + i * STEP);
      chk($sformatf("t3_we_addr%0d", i), we_addr_q[wb+i], ea);
      chk($sformatf("t3_we_data%0d", i), we_data_q[wb+i], 8'h11 * (i + 1));
    end

    // 4: burst read from 0x10, model returns addr ^ 0xFF
    rd_mode = 1;
    wb = we_cnt; rb = re_cnt;
    spi_frame(8'h10, 24, 0);
    chk("t4_re_count", re_cnt - rb, 4);
    for (int i = 0; i < 4; i++) begin
      ea = 7'(8'h10 + i * STEP);
      chk($sformatf("t4_re_addr%0d", i), re_addr_q[rb+i], ea);
    end
    for (int i = 0; i < 3; i++) begin
      ea = 7'(8'h10 + i * STEP);
      chk($sformatf("t4_miso_word%0d", i), rx[i], {1'b0, ea} ^ 8'hFF);
    end
    chk("t4_no_we", we_cnt - wb, 0);
    chk("t4_never_both", both_cnt, 0);

    // 5: aborted write after 5 bits, CS released on the last rise, SCLK with CS high
    wb = we_cnt; rb = re_cnt;
    tx[0] = 8'hC3;
    spi_frame(8'h85, 5, 0);
    chk("t5_abort_no_we", we_cnt - wb, 0);
    chk("t5_abort_addr_hold", reg_addr_o, 7'h05);
    chk("t5_abort_wdata_hold", reg_wdata_o, 8'h33);
    chk("t5_abort_idle", xfer_active_o, 1'b0);
    spi_frame(8'h85, 8, 1);
    chk("t5_cs_on_last_rise", we_cnt - wb, 0);
    for (int k = 0; k < 8; k++) begin
      sclk_i = 1'b1; wait_clks(HALF);
      sclk_i = 1'b0; wait_clks(HALF);
    end
    chk("t5_sclk_cs_high_idle", xfer_active_o, 1'b0);
    chk("t5_sclk_cs_high_strobes", (we_cnt - wb) + (re_cnt - rb), 0);
    tx[0] = 8'h5A;
    spi_frame(8'hA0, 8, 0);
    chk("t5_clean_we_count", we_cnt - wb, 1);
    chk("t5_clean_we_addr", we_addr_q[wb], 7'h20);
    chk("t5_clean_we_data", we_data_q[wb], 8'h5A);

    // 6: reset during a burst, then a burst to observe address stepping
    wb = we_cnt;
    tx[0] = 8'h77; tx[1] = 8'h88;
    spi_frame(8'hC0, 12, 2);
    chk("t6_mid_active", xfer_active_o, 1'b1);
    chk("t6_mid_we_count", we_cnt - wb, 1);
    chk("t6_mid_addr", reg_addr_o, 7'(8'h40 + STEP));
    rst_ni = 1'b0;
    cs_i = 1'b1;
    #1;
    chk("t6_reset_outputs", {reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, miso_o, xfer_active_o}, 32'h0);
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(4);
    chk("t6_idle_after_reset", xfer_active_o, 1'b0);
    wb = we_cnt;
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC;
    spi_frame(8'hC0, 24, 0);
    chk("t6_burst_we_count", we_cnt - wb, 3);
    for (int i = 0; i < 3; i++) begin
      ea = 7'(8'h40 + i * STEP);
      chk($sformatf("t6_burst_addr%0d", i), we_addr_q[wb+i], ea);
    end
    chk("t6_burst_last_data", we_data_q[wb+2], 8'hCC);
    chk("final_never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
